// File: rtl/demux_rr_sched_if.sv
`default_nettype none
// ============================================================================
// demux_rr_sched_if : producer channel and eight consumer lanes of the steerer
// Revision: 1.0
// ============================================================================
interface demux_rr_sched_if #(
   parameter int WIDTH = 8
);
   logic             in_val;
   logic             in_rdy;
   logic [WIDTH-1:0] in_msg;
   logic [2:0]       in_dest;
   logic             in_mode;
   logic [7:0]       out_val;
   logic [7:0]       out_rdy;
   logic [WIDTH-1:0] out_msg;
   logic [2:0]       out_sel;
   logic [7:0]       skip_count;

   modport master (
      output in_val,
      output in_msg,
      output in_dest,
      output in_mode,
      output out_rdy,
      input  in_rdy,
      input  out_val,
      input  out_msg,
      input  out_sel,
      input  skip_count
   );

   modport slave (
      input  in_val,
      input  in_msg,
      input  in_dest,
      input  in_mode,
      input  out_rdy,
      output in_rdy,
      output out_val,
      output out_msg,
      output out_sel,
      output skip_count
   );
endinterface
`default_nettype wire

// File: rtl/demux_rr_sched.sv
`default_nettype none
// ============================================================================
// demux_rr_sched : one-entry buffered 1-to-8 message steerer, directed or
//                  round-robin with timeout-based skipping of stalled lanes
// Revision: 1.0
// ============================================================================
module demux_rr_sched #(
   parameter int WIDTH      = 8,
   parameter int SKIP_LIMIT = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   demux_rr_sched_if.slave bus
);

   typedef enum logic [0:0] {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_e;

   localparam logic [7:0] c_SKIP_LIMIT = 8'(SKIP_LIMIT);
   localparam bit         c_SKIP_EN    = (SKIP_LIMIT > 0);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] msg_q, msg_d;
   logic [2:0]       dest_q, dest_d;
   logic             mode_q, mode_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [7:0]       stall_q, stall_d;
   logic [7:0]       skip_q, skip_d;
   logic [7:0]       out_val_q, out_val_d;
   logic [2:0]       out_sel_q, out_sel_d;

   logic [2:0]       w_tgt;
   logic [2:0]       w_tgt_nxt;
   logic             w_out_fire;
   logic             w_in_rdy;
   logic             w_in_fire;

   assign w_out_fire = |(out_val_q & bus.out_rdy);
   assign w_in_rdy   = reset_n & ((state_q == S_EMPTY) | w_out_fire);
   assign w_in_fire  = bus.in_val & w_in_rdy;
   assign w_tgt      = mode_q ? ptr_q : dest_q;

   always_comb begin
      state_d   = state_q;
      msg_d     = msg_q;
      dest_d    = dest_q;
      mode_d    = mode_q;
      ptr_d     = ptr_q;
      stall_d   = stall_q;
      skip_d    = skip_q;
      w_tgt_nxt = 3'd0;
      out_val_d = 8'd0;
      out_sel_d = out_sel_q;

      if (state_q == S_FULL) begin
         if (w_out_fire) begin
            stall_d = 8'd0;
            state_d = S_EMPTY;
            if (mode_q) begin
               ptr_d = w_tgt + 3'd1;
            end
         end else if (mode_q && c_SKIP_EN) begin
            // In round-robin a missed transfer always means out_rdy[ptr] was low.
            if (stall_q + 8'd1 == c_SKIP_LIMIT) begin
               stall_d = 8'd0;
               ptr_d   = ptr_q + 3'd1;
               if (skip_q != 8'hFF) begin
                  skip_d = skip_q + 8'd1;
               end
            end else begin
               stall_d = stall_q + 8'd1;
            end
         end
      end

      if (w_in_fire) begin
         state_d = S_FULL;
         msg_d   = bus.in_msg;
         dest_d  = bus.in_dest;
         mode_d  = bus.in_mode;
      end

      // Steering outputs are precomputed so they leave straight from flops.
      w_tgt_nxt = mode_d ? ptr_d : dest_d;
      if (state_d == S_FULL) begin
         out_val_d = 8'd1 << w_tgt_nxt;
         out_sel_d = w_tgt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_EMPTY;
         msg_q     <= '0;
         dest_q    <= 3'd0;
         mode_q    <= 1'b0;
         ptr_q     <= 3'd0;
         stall_q   <= 8'd0;
         skip_q    <= 8'd0;
         out_val_q <= 8'd0;
         out_sel_q <= 3'd0;
      end else begin
         state_q   <= state_d;
         msg_q     <= msg_d;
         dest_q    <= dest_d;
         mode_q    <= mode_d;
         ptr_q     <= ptr_d;
         stall_q   <= stall_d;
         skip_q    <= skip_d;
         out_val_q <= out_val_d;
         out_sel_q <= out_sel_d;
      end
   end

   assign bus.in_rdy     = w_in_rdy;
   assign bus.out_val    = out_val_q;
   assign bus.out_msg    = msg_q;
   assign bus.out_sel    = out_sel_q;
   assign bus.skip_count = skip_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_rr_sched.sv
`default_nettype none
// ============================================================================
// tb_demux_rr_sched : scoreboard-driven bench for the 1-to-8 message steerer
// Revision: 1.0
// ============================================================================
module tb_demux_rr_sched;

   typedef struct {
      logic [7:0] msg;
      logic [2:0] dest;
      logic       mode;
   } stim_t;

   typedef struct {
      logic [2:0] ch;
      logic [7:0] msg;
   } exp_t;

   logic clk;
   logic reset_n;
   int   n_pass  = 0;
   int   n_total = 0;
   logic [2:0] m_ptr  = 3'd0;
   logic [7:0] m_skip = 8'd0;
   exp_t  sb[$];
   stim_t stim[$];

   demux_rr_sched_if #(.WIDTH(8)) bus ();

   demux_rr_sched #(.WIDTH(8), .SKIP_LIMIT(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      reset_n     = 1'b0;
      bus.in_val  = 1'b0;
      bus.in_msg  = 8'h00;
      bus.in_dest = 3'd0;
      bus.in_mode = 1'b0;
      bus.out_rdy = 8'hFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_total++;
      if (bus.in_rdy !== 1'b0) $display("FAIL reset_in_rdy_low: got %b want 0", bus.in_rdy);
      else n_pass++;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      n_total++;
      if (bus.out_val !== 8'h00 || bus.out_msg !== 8'h00 || bus.out_sel !== 3'd0)
         $display("FAIL reset_outputs: got val=%h msg=%h sel=%0d want 00/00/0",
                  bus.out_val, bus.out_msg, bus.out_sel);
      else n_pass++;
      n_total++;
      if (bus.skip_count !== 8'd0 || bus.in_rdy !== 1'b1)
         $display("FAIL reset_skip_rdy: got skip=%0d rdy=%b want 0/1", bus.skip_count, bus.in_rdy);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      int   idx = 0;
      int   cyc = 0;
      exp_t e;
      bus.out_rdy = 8'hFF;
      stim = '{'{8'hA5, 3'd3, 1'b0}, '{8'h3C, 3'd7, 1'b0}};
      while ((idx < stim.size() || sb.size() != 0) && cyc < 20) begin
         bus.in_val = (idx < stim.size());
         if (idx < stim.size()) begin
            bus.in_msg = stim[idx].msg; bus.in_dest = stim[idx].dest; bus.in_mode = stim[idx].mode;
         end
         @(negedge clk);
         if (|(bus.out_val & bus.out_rdy)) begin
            n_total++;
            if (sb.size() == 0) $display("FAIL dir_unexpected_out: got val=%h want none", bus.out_val);
            else begin
               e = sb.pop_front();
               if (bus.out_val !== (8'd1 << e.ch) || bus.out_msg !== e.msg)
                  $display("FAIL dir_out: got val=%h msg=%h want val=%h msg=%h",
                           bus.out_val, bus.out_msg, 8'd1 << e.ch, e.msg);
               else n_pass++;
            end
         end
         n_total++;
         if (bus.in_rdy !== 1'b1) $display("FAIL dir_in_rdy: got %b want 1 (cycle %0d)", bus.in_rdy, cyc);
         else n_pass++;
         if (bus.in_val && bus.in_rdy) begin
            sb.push_back('{stim[idx].mode ? m_ptr : stim[idx].dest, stim[idx].msg});
            if (stim[idx].mode) m_ptr = m_ptr + 3'd1;
            idx++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.in_val = 1'b0;
      n_total++;
      if (cyc !== 3) $display("FAIL dir_latency: got %0d cycles want 3", cyc);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int   idx = 0;
      int   cyc = 0;
      exp_t e;
      bus.out_rdy = 8'hFF;
      stim.delete();
      for (int i = 0; i < 10; i++) stim.push_back('{8'(i), 3'd0, 1'b1});
      while ((idx < stim.size() || sb.size() != 0) && cyc < 40) begin
         bus.in_val = (idx < stim.size());
         if (idx < stim.size()) begin
            bus.in_msg = stim[idx].msg; bus.in_dest = stim[idx].dest; bus.in_mode = stim[idx].mode;
         end
         @(negedge clk);
         if (|(bus.out_val & bus.out_rdy)) begin
            n_total++;
            if (sb.size() == 0) $display("FAIL b2b_unexpected_out: got val=%h want none", bus.out_val);
            else begin
               e = sb.pop_front();
               if (bus.out_val !== (8'd1 << e.ch) || bus.out_msg !== e.msg)
                  $display("FAIL b2b_out: got val=%h msg=%h want val=%h msg=%h",
                           bus.out_val, bus.out_msg, 8'd1 << e.ch, e.msg);
               else n_pass++;
            end
         end
         if (bus.in_val && bus.in_rdy) begin
            sb.push_back('{stim[idx].mode ? m_ptr : stim[idx].dest, stim[idx].msg});
            if (stim[idx].mode) m_ptr = m_ptr + 3'd1;
            idx++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.in_val = 1'b0;
      n_total++;
      if (cyc !== 11) $display("FAIL b2b_throughput: got %0d cycles want 11", cyc);
      else n_pass++;
   endtask

   task automatic test_interleave();
      int   idx = 0;
      int   cyc = 0;
      exp_t e;
      bus.out_rdy = 8'hFF;
      stim = '{'{8'h11, 3'd0, 1'b1}, '{8'h22, 3'd6, 1'b0}, '{8'h33, 3'd1, 1'b1}, '{8'h44, 3'd7, 1'b1}};
      while ((idx < stim.size() || sb.size() != 0) && cyc < 40) begin
         bus.in_val = (idx < stim.size());
         if (idx < stim.size()) begin
            bus.in_msg = stim[idx].msg; bus.in_dest = stim[idx].dest; bus.in_mode = stim[idx].mode;
         end
         @(negedge clk);
         if (|(bus.out_val & bus.out_rdy)) begin
            n_total++;
            if (sb.size() == 0) $display("FAIL mix_unexpected_out: got val=%h want none", bus.out_val);
            else begin
               e = sb.pop_front();
               if (bus.out_val !== (8'd1 << e.ch) || bus.out_msg !== e.msg || bus.out_sel !== e.ch)
                  $display("FAIL mix_out: got val=%h msg=%h sel=%0d want val=%h msg=%h sel=%0d",
                           bus.out_val, bus.out_msg, bus.out_sel, 8'd1 << e.ch, e.msg, e.ch);
               else n_pass++;
            end
         end
         if (bus.in_val && bus.in_rdy) begin
            sb.push_back('{stim[idx].mode ? m_ptr : stim[idx].dest, stim[idx].msg});
            if (stim[idx].mode) m_ptr = m_ptr + 3'd1;
            idx++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.in_val = 1'b0;
      n_total++;
      if (sb.size() != 0 || idx != stim.size())
         $display("FAIL mix_drain: got %0d pending %0d unsent want 0/0", sb.size(), stim.size() - idx);
      else n_pass++;
   endtask

   task automatic test_skip();
      exp_t e;
      reset_n    = 1'b0;
      bus.in_val = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      m_ptr   = 3'd0;
      m_skip  = 8'd0;
      bus.out_rdy = 8'hFE;
      bus.in_val = 1'b1; bus.in_msg = 8'h55; bus.in_dest = 3'd0; bus.in_mode = 1'b1;
      @(negedge clk);
      n_total++;
      if (bus.in_rdy !== 1'b1) $display("FAIL skip_accept: got rdy=%b want 1", bus.in_rdy);
      else begin
         n_pass++;
         // Lane 0 is blocked, so the message should land one lane further on.
         sb.push_back('{m_ptr + 3'd1, 8'h55});
      end
      @(posedge clk); #1;
      bus.in_val = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_total++;
         if (bus.out_val !== 8'h01 || bus.in_rdy !== 1'b0 || bus.out_msg !== 8'h55)
            $display("FAIL skip_stall: got val=%h rdy=%b msg=%h want 01/0/55 (cycle %0d)",
                     bus.out_val, bus.in_rdy, bus.out_msg, i);
         else n_pass++;
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_total++;
      if (sb.size() == 0 || !(|(bus.out_val & bus.out_rdy)))
         $display("FAIL skip_move: got val=%h want a transfer", bus.out_val);
      else begin
         e = sb.pop_front();
         if (bus.out_val !== (8'd1 << e.ch) || bus.out_msg !== e.msg || bus.skip_count !== 8'd1)
            $display("FAIL skip_move: got val=%h msg=%h skip=%0d want val=%h msg=%h skip=1",
                     bus.out_val, bus.out_msg, bus.skip_count, 8'd1 << e.ch, e.msg);
         else n_pass++;
      end
      @(posedge clk); #1;
      m_ptr  = 3'd2;
      m_skip = 8'd1;
      @(negedge clk);
      n_total++;
      if (bus.out_val !== 8'h00 || bus.skip_count !== m_skip)
         $display("FAIL skip_after: got val=%h skip=%0d want 00/%0d", bus.out_val, bus.skip_count, m_skip);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_directed_stall();
      exp_t e;
      bus.out_rdy = ~8'h20;
      bus.in_val = 1'b1; bus.in_msg = 8'h77; bus.in_dest = 3'd5; bus.in_mode = 1'b0;
      @(negedge clk);
      if (bus.in_rdy === 1'b1) sb.push_back('{3'd5, 8'h77});
      @(posedge clk); #1;
      bus.in_val = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_total++;
         if (bus.out_val !== 8'h20 || bus.out_msg !== 8'h77 || bus.skip_count !== m_skip)
            $display("FAIL dstall_hold: got val=%h msg=%h skip=%0d want 20/77/%0d (cycle %0d)",
                     bus.out_val, bus.out_msg, bus.skip_count, m_skip, i);
         else n_pass++;
         @(posedge clk); #1;
      end
      bus.out_rdy = 8'hFF;
      @(negedge clk);
      n_total++;
      if (sb.size() == 0 || !(|(bus.out_val & bus.out_rdy)))
         $display("FAIL dstall_release: got val=%h want a transfer", bus.out_val);
      else begin
         e = sb.pop_front();
         if (bus.out_val !== (8'd1 << e.ch) || bus.out_msg !== e.msg || bus.skip_count !== m_skip)
            $display("FAIL dstall_release: got val=%h msg=%h skip=%0d want val=%h msg=%h skip=%0d",
                     bus.out_val, bus.out_msg, bus.skip_count, 8'd1 << e.ch, e.msg, m_skip);
         else n_pass++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bus.out_rdy = 8'h00;
      bus.in_val = 1'b1; bus.in_msg = 8'h99; bus.in_dest = 3'd0; bus.in_mode = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      bus.in_val = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_total++;
         if (bus.out_val !== (8'd1 << m_ptr))
            $display("FAIL rmid_full: got val=%h want %h", bus.out_val, 8'd1 << m_ptr);
         else n_pass++;
         @(posedge clk); #1;
      end
      reset_n = 1'b0;
      @(negedge clk);
      n_total++;
      if (bus.in_rdy !== 1'b0) $display("FAIL rmid_rdy_low: got %b want 0", bus.in_rdy);
      else n_pass++;
      @(posedge clk); #1;
      reset_n     = 1'b1;
      bus.out_rdy = 8'hFF;
      m_ptr       = 3'd0;
      m_skip      = 8'd0;
      @(negedge clk);
      n_total++;
      if (bus.out_val !== 8'h00 || bus.skip_count !== 8'd0 || bus.in_rdy !== 1'b1 || bus.out_msg !== 8'h00)
         $display("FAIL rmid_after: got val=%h skip=%0d rdy=%b msg=%h want 00/0/1/00",
                  bus.out_val, bus.skip_count, bus.in_rdy, bus.out_msg);
      else n_pass++;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_total++;
         if (bus.out_val !== 8'h00) $display("FAIL rmid_discard: got val=%h want 00", bus.out_val);
         else n_pass++;
         @(posedge clk); #1;
      end
      bus.in_val = 1'b1; bus.in_msg = 8'hC3; bus.in_mode = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      bus.in_val = 1'b0;
      @(negedge clk);
      n_total++;
      if (bus.out_val !== (8'd1 << m_ptr) || bus.out_msg !== 8'hC3)
         $display("FAIL rmid_ptr0: got val=%h msg=%h want %h/c3", bus.out_val, bus.out_msg, 8'd1 << m_ptr);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_interleave();
      test_skip();
      test_directed_stall();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/demux_rr_sched.md
Name: demux_rr_sched

Overview:
- Sequencing controller for the 1-bit 1-to-8 demux datapath, widened to a WIDTH-bit message with latency-insensitive val/rdy channels.
- Accepts one message stream and steers each message to one of 8 output channels.
- Two steering modes: directed, where the message carries its destination, and round-robin, where a pointer sequences the channels and skips a stalled channel after a configurable timeout.
- Sits between a single producer and eight consumer lanes.

Parameters:
- WIDTH, 8, message width in bits.
- SKIP_LIMIT, 4, consecutive stalled cycles before round-robin skips a channel. 0 disables skipping. Legal range 0..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_val  input  1  input message valid.
- in_rdy  output  1  input ready.
- in_msg  input  WIDTH  input message.
- in_dest  input  3  destination channel; used only when in_mode=0.
- in_mode  input  1  0 = directed, 1 = round-robin; sampled with the message.
- out_val  output  8  one-hot per-channel valid, or all zero.
- out_rdy  input  8  per-channel ready.
- out_msg  output  WIDTH  message broadcast to all channels; qualified by out_val.
- out_sel  output  3  channel currently targeted (debug/steering).
- skip_count  output  8  saturating count of round-robin skips since reset.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - buffer empty, ptr=0, stall counter=0, skip_count=0.
  - out_val=0, out_msg=0, out_sel=0.
  - in_rdy=0 while reset_n=0.
- Storage and latency:
  - One-entry holding buffer {msg, dest, mode}, states EMPTY and FULL.
  - Input fire = in_val & in_rdy; output fire = |(out_val & out_rdy).
  - in_rdy = reset_n & (EMPTY | output fire). Output fire from FULL with a simultaneous input fire reloads the buffer, so throughput is 1 message/cycle.
  - Latency is 1 cycle: a message captured at edge N is presented at outputs from cycle N+1. There is no combinational in-to-out path.
- EMPTY state:
  - out_val=0; out_msg holds its last value.
  - Input fire -> FULL.
- FULL state:
  - Target channel t: dest if mode=0, ptr if mode=1. out_sel=t.
  - out_val = (1 << t); out_msg = buffered msg.
  - out_val never depends combinationally on out_rdy.
- Output fire transitions:
  - Directed: ptr unchanged.
  - Round-robin: ptr <= t+1 mod 8 (7 wraps to 0).
  - Stall counter cleared.
  - Next state is FULL if input fired the same cycle, else EMPTY.
- Stall and skip (mode=1 and SKIP_LIMIT>0 only):
  - Each FULL cycle with out_rdy[ptr]=0 increments the stall counter.
  - When the counter reaches SKIP_LIMIT at an edge: ptr <= ptr+1 mod 8, counter <= 0, skip_count increments and saturates at 255.
  - The message stays buffered; out_val moves to the new channel in the next cycle. This is the only case in which an asserted out_val retracts without a transfer. Consumers treat it as non-binding.
- Directed mode never skips; a directed message waits indefinitely on its channel.
- ptr persists across mode changes; directed traffic does not disturb the round-robin order.
- Mid-operation reset discards the buffered message; no out_val is asserted in the cycle after reset deasserts.

Test Plan:
- Reset, then directed messages 0xA5 (dest 3) and 0x3C (dest 7) with all out_rdy=1 -> out_val=0x08 with out_msg=0xA5, then out_val=0x80 with out_msg=0x3C on consecutive cycles. in_rdy stays 1 and ptr stays 0.
- Ten back-to-back round-robin messages 0x00..0x09 with all out_rdy=1 -> out_val sequence 0x01,0x02,...,0x80,0x01,0x02. One transfer per cycle; ptr=2 at end.
- Round-robin with out_rdy=0xFE, SKIP_LIMIT=4, message 0x55 -> out_val=0x01 for 4 cycles, then 0x02, and 0x55 transfers on channel 1. skip_count=1, ptr=2, in_rdy=0 during the stall.
- Directed message to dest 5 with out_rdy[5]=0 for 20 cycles, then 1 -> out_val=0x20 held for all 20 cycles, no skip, transfer on cycle 21, skip_count unchanged.
- Interleave: round-robin, directed(6), round-robin, with ptr=2 -> channels 2, 6, 3. ptr ends at 4.
- Assert reset_n=0 for 1 cycle while FULL and stalled -> next cycle out_val=0, skip_count=0, ptr=0. The buffered message never appears, and in_rdy=1 after reset deasserts.
